// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage: opcode field, NOP bubble,
// run-control FSM encoding and the PC source select.
package mips_pkg;

    localparam int          OPCODE_HI   = 31;
    localparam int          OPCODE_LO   = 26;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;
    localparam logic [31:0] NOP_INSTR   = 32'h0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, the instruction memory, the hazard/branch logic and ID.
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    import mips_pkg::*;

    // There is no valid/ready pair: if_id_valid qualifies the IF/ID contents every
    // cycle and the only backpressure is stall, which freezes PC and IF/ID in place.
    logic               stall;
    logic               flush;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic [31:0]        imem_addr;
    logic [31:0]        imem_data;
    logic [31:0]        if_id_instr;
    logic [31:0]        if_id_pc_plus1;
    logic               if_id_valid;
    logic               halted;
    logic [CNT_W-1:0]   fetch_count;
    fetch_state_t       state;

    modport master (
        input  stall, flush, branch_taken, branch_target, imem_data,
        output imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, halted, fetch_count, state
    );

    modport slave (
        output stall, flush, branch_taken, branch_target, imem_data,
        input  imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid, halted, fetch_count, state
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with asynchronous reset and a hold / increment / redirect mux.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  pc_sel_t     sel,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1
);

    // Word-addressed; 32'hFFFFFFFF rolls over to 0 naturally.
    assign pc_plus1 = pc + 32'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_INC:    pc <= pc_plus1;
                PC_TARGET: pc <= target;
                default:   pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and the IF/ID register, with BOOT/RUN/HALT run control,
// stall, flush, branch redirect and a saturating fetch counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'd1,
    parameter logic [5:0]  HALT_OPCODE = mips_pkg::HALT_OPCODE,
    parameter int          CNT_W       = 16
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master bus
);
    import mips_pkg::*;

    fetch_state_t       state;
    pc_sel_t            pc_sel;
    logic [31:0]        pc;
    logic [31:0]        pc_plus1;
    logic [31:0]        instr_r;
    logic [31:0]        pp_r;
    logic               valid_r;
    logic               halted_r;
    logic [CNT_W-1:0]   count_r;
    logic               is_halt;

    assign is_halt = (opcode_of(bus.imem_data) == HALT_OPCODE);

    // Mirrors the priority in the FSM below; a latched halt word parks the PC on itself.
    always_comb begin
        pc_sel = PC_HOLD;
        case (state)
            RUN: begin
                if (bus.branch_taken)  pc_sel = PC_TARGET;
                else if (bus.stall)    pc_sel = PC_HOLD;
                else if (bus.flush)    pc_sel = PC_INC;
                else if (is_halt)      pc_sel = PC_HOLD;
                else                   pc_sel = PC_INC;
            end
            HALT: begin
                if (bus.branch_taken)  pc_sel = PC_TARGET;
            end
            default: pc_sel = PC_HOLD;
        endcase
    end

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clock    (clock),
        .reset    (reset),
        .sel      (pc_sel),
        .target   (bus.branch_target),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            instr_r  <= NOP_INSTR;
            pp_r     <= 32'h0;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            count_r  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    instr_r <= NOP_INSTR;
                    pp_r    <= 32'h0;
                    valid_r <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    if (bus.branch_taken || bus.flush) begin
                        // Also covers stall together with flush: the bubble wins over the hold.
                        instr_r <= NOP_INSTR;
                        pp_r    <= 32'h0;
                        valid_r <= 1'b0;
                        if (bus.stall && !bus.branch_taken) begin
                            instr_r <= NOP_INSTR;
                        end
                    end else if (!bus.stall) begin
                        instr_r <= bus.imem_data;
                        pp_r    <= pc_plus1;
                        valid_r <= 1'b1;
                        if (count_r != '1) count_r <= count_r + 1'b1;
                        if (is_halt) begin
                            state    <= HALT;
                            halted_r <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    instr_r <= NOP_INSTR;
                    pp_r    <= 32'h0;
                    valid_r <= 1'b0;
                    if (bus.branch_taken) begin
                        state    <= RUN;
                        halted_r <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr      = pc;
    assign bus.if_id_instr    = instr_r;
    assign bus.if_id_pc_plus1 = pp_r;
    assign bus.if_id_valid    = valid_r;
    assign bus.halted         = halted_r;
    assign bus.fetch_count    = count_r;
    assign bus.state          = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic,
// scored against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
    import mips_pkg::*;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      pp;
        logic             valid;
        logic             halted;
        logic [CNT_W-1:0] count;
        logic [1:0]       state;
    } exp_t;

    localparam int W = $bits(exp_t);

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_stage_if #(.CNT_W(CNT_W)) bus ();

    fetch_stage #(
        .RESET_PC    (32'd1),
        .HALT_OPCODE (6'b111111),
        .CNT_W       (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // reference model state: mode 0 = boot, 1 = run, 2 = halt
    logic [31:0]      m_pc;
    logic [31:0]      m_instr;
    logic [31:0]      m_pp;
    logic             m_valid;
    logic [CNT_W-1:0] m_count;
    int               m_mode;
    logic             halt_en;
    logic [31:0]      halt_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (halt_en && a == halt_addr) return {6'b111111, 26'h0};
        return (a * 32'd16) & 32'h03FF_FFFF;
    endfunction

    task automatic model_reset();
        m_pc = 32'd1; m_instr = 32'h0; m_pp = 32'h0; m_valid = 1'b0;
        m_count = '0; m_mode = 0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_pp = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic bt,
                              input logic [31:0] tgt, input logic [31:0] dat);
        case (m_mode)
            0: begin
                model_bubble();
                m_mode = 1;
            end
            1: begin
                if (bt) begin
                    m_pc = tgt;
                    model_bubble();
                end else if (st) begin
                    if (fl) model_bubble();
                end else if (fl) begin
                    m_pc = m_pc + 32'd1;
                    model_bubble();
                end else begin
                    m_instr = dat;
                    m_pp    = m_pc + 32'd1;
                    m_valid = 1'b1;
                    if (m_count != '1) m_count = m_count + 1'b1;
                    if (dat[31:26] == 6'b111111) m_mode = 2;
                    else m_pc = m_pc + 32'd1;
                end
            end
            default: begin
                model_bubble();
                if (bt) begin
                    m_pc   = tgt;
                    m_mode = 1;
                end
            end
        endcase
    endtask

    function automatic logic [W-1:0] pack_exp();
        exp_t e;
        e.pc     = m_pc;
        e.instr  = m_instr;
        e.pp     = m_pp;
        e.valid  = m_valid;
        e.halted = (m_mode == 2);
        e.count  = m_count;
        e.state  = 2'(m_mode);
        return e;
    endfunction

    // driver: apply one cycle of inputs now (at a negedge), predict, then wait for the next negedge
    task automatic cycle(input logic st, input logic fl, input logic bt,
                         input logic [31:0] tgt, input logic rnd);
        logic [31:0] dat;
        dat = word_at(m_pc);
        if (rnd) begin
            dat = $urandom();
            if ($urandom_range(0, 9) == 0) dat[31:26] = 6'b111111;
            else if (dat[31:26] == 6'b111111) dat[31:26] = 6'b000000;
        end
        bus.stall         = st;
        bus.flush         = fl;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bus.imem_data     = dat;
        model_step(st, fl, bt, tgt, dat);
        exp_q.push_back(pack_exp());
        @(negedge clock);
    endtask

    // monitor: one expected entry per clock edge, compared just after the edge
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            check("imem_addr",      bus.imem_addr,      e.pc);
            check("if_id_instr",    bus.if_id_instr,    e.instr);
            check("if_id_pc_plus1", bus.if_id_pc_plus1, e.pp);
            check("if_id_valid",    32'(bus.if_id_valid), 32'(e.valid));
            check("halted",         32'(bus.halted),      32'(e.halted));
            check("fetch_count",    32'(bus.fetch_count), 32'(e.count));
            check("state",          32'(bus.state),       32'(e.state));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0; bus.imem_data = 32'h0;
        halt_en = 1'b0; halt_addr = 32'h0;
        model_reset();

        // reset values
        repeat (2) @(negedge clock);
        check("rst_pc",     bus.imem_addr, 32'd1);
        check("rst_instr",  bus.if_id_instr, 32'h0);
        check("rst_pp",     bus.if_id_pc_plus1, 32'h0);
        check("rst_valid",  32'(bus.if_id_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_count",  32'(bus.fetch_count), 32'd0);
        check("rst_state",  32'(bus.state), 32'(BOOT));
        reset = 1'b0;

        // 1: boot bubble then three sequential fetches
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t1_instr", bus.if_id_instr, 32'd48);
        check("t1_pp",    bus.if_id_pc_plus1, 32'd4);
        check("t1_count", 32'(bus.fetch_count), 32'd3);

        // 2: stall two cycles at pc=5
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_pc", bus.imem_addr, 32'd5);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_pc_hold",    bus.imem_addr, 32'd5);
        check("t2_instr_hold", bus.if_id_instr, 32'd64);
        check("t2_count_hold", 32'(bus.fetch_count), 32'd4);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t2_resume_instr", bus.if_id_instr, 32'd80);
        check("t2_resume_pp",    bus.if_id_pc_plus1, 32'd6);

        // 3: branch overrides stall
        cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
        check("t3_pc",    bus.imem_addr, 32'h40);
        check("t3_valid", 32'(bus.if_id_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t3_pp", bus.if_id_pc_plus1, 32'h41);

        // 4: halt word at pc=9, then redirect out of HALT
        cycle(1'b0, 1'b0, 1'b1, 32'd9, 1'b0);
        halt_en = 1'b1; halt_addr = 32'd9;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t4_instr",  bus.if_id_instr, {6'b111111, 26'h0});
        check("t4_valid",  32'(bus.if_id_valid), 32'd1);
        check("t4_halted", 32'(bus.halted), 32'd1);
        check("t4_pc",     bus.imem_addr, 32'd9);
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t4_bubble",  32'(bus.if_id_valid), 32'd0);
        check("t4_pc_hold", bus.imem_addr, 32'd9);
        cycle(1'b0, 1'b0, 1'b1, 32'd3, 1'b0);
        check("t4_unhalt", 32'(bus.halted), 32'd0);
        check("t4_redir",  bus.imem_addr, 32'd3);
        halt_en = 1'b0;

        // 5: PC wrap
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t5_pc_wrap", bus.imem_addr, 32'h0);
        check("t5_pp_wrap", bus.if_id_pc_plus1, 32'h0);
        check("t5_valid",   32'(bus.if_id_valid), 32'd1);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 64));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, tgt, 1'b1);
        end

        // count saturation
        cycle(1'b0, 1'b0, 1'b1, 32'd100, 1'b0);
        repeat (300) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t5_count_sat", 32'(bus.fetch_count), 32'(8'hFF));

        // 6: async reset mid-cycle while halted with stall high
        halt_en = 1'b1; halt_addr = m_pc;
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_in_halt", 32'(bus.halted), 32'd1);
        bus.stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("t6_pc",     bus.imem_addr, 32'd1);
        check("t6_instr",  bus.if_id_instr, 32'h0);
        check("t6_valid",  32'(bus.if_id_valid), 32'd0);
        check("t6_halted", 32'(bus.halted), 32'd0);
        check("t6_count",  32'(bus.fetch_count), 32'd0);
        check("t6_state",  32'(bus.state), 32'(BOOT));
        exp_q.delete();
        model_reset();
        halt_en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus.stall = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_refetch_instr", bus.if_id_instr, 32'd32);
        check("t6_refetch_pp",    bus.if_id_pc_plus1, 32'd3);

        @(posedge clock);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
